fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32, word-aligned read address.
REQ-006 SHALL have port imem_ack, input, 1, read data valid for the outstanding request this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, read data qualified by imem_ack.
REQ-008 SHALL have port redirect, input, 1, control-flow change from execute (taken branch, jal, jalr).
REQ-009 SHALL have port redirect_pc, input, 32, target address qualified by redirect.
REQ-010 SHALL have port instr_valid, output, 1, instr/instr_pc hold a fetched instruction.
REQ-011 SHALL have port instr, output, 32, instruction word presented to the decoder.
REQ-012 SHALL have port instr_pc, output, 32, address of instr.
REQ-013 SHALL have port instr_ready, input, 1, decoder accepts instr this cycle.

Function
REQ-014 SHALL keep a fetch-PC register and a 2-entry FIFO of {instr, pc}; transfer to decoder = instr_valid && instr_ready.
REQ-015 SHALL drive instr/instr_pc from the FIFO head; instr_valid = FIFO non-empty; when empty instr = 32'h0000_0013 (NOP), instr_pc = 0.
REQ-016 SHALL implement states IDLE (no request), REQ (request for current fetch PC), DROP (request outstanding whose data is stale).
REQ-017 SHALL hold at most one outstanding request; enter/stay REQ only when FIFO count after this cycle's pop is < 2.
REQ-018 In REQ/DROP SHALL hold imem_req=1 and imem_addr stable until imem_ack; imem_ack may arrive in the first cycle of the request.
REQ-019 On imem_ack in REQ without redirect: push {imem_rdata, fetch PC}, fetch PC += 4 (mod 2^32 wrap), next state REQ if space else IDLE.
REQ-020 Push and pop in the same cycle SHALL both occur; count unchanged; never overflow nor underflow.
REQ-021 Pushed entry SHALL be visible on instr_valid the cycle after imem_ack (1-cycle latency ack-to-decode).
REQ-022 On redirect: flush FIFO (instr_valid=0 next cycle), fetch PC = {redirect_pc[31:2], 2'b00}; redirect overrides any same-cycle pop or push.
REQ-023 Redirect in REQ without same-cycle ack SHALL go to DROP; in DROP the acked data is discarded, then state goes to REQ at the new fetch PC.
REQ-024 Redirect with same-cycle imem_ack SHALL discard the data and go to REQ at the new PC (no DROP).
REQ-025 Further redirects while in DROP SHALL only update fetch PC; state stays DROP until ack.
REQ-026 IDLE SHALL go to REQ when FIFO has space; imem_req=0 and imem_addr = fetch PC in IDLE.

Reset
REQ-027 n_rst low SHALL immediately: state IDLE, FIFO empty, fetch PC = RESET_PC, imem_req=0, instr_valid=0, instr=32'h0000_0013, instr_pc=0.
REQ-028 First cycle after n_rst deasserts SHALL assert imem_req with imem_addr = RESET_PC.
REQ-029 Reset mid-request SHALL abandon the request; any ack during or after reset for it is ignored.

Verification
REQ-030 Reset, instr_ready=1, memory acks each request after 1 wait cycle with data=addr -> instr_pc sequence 0,4,8,... with instr=instr_pc, no gaps beyond memory latency.
REQ-031 instr_ready=0, zero-wait acks -> exactly 2 requests (addr 0,4), imem_req=0 afterwards; raise instr_ready -> pops 0 then 4, fetch resumes at 8.
REQ-032 Redirect to 32'h0000_0103 while request for 8 outstanding (ack 3 cycles later) -> DROP, data for 8 discarded, next request addr 32'h0000_0100, first valid instr_pc 32'h100.
REQ-033 Redirect with same-cycle ack and same-cycle pop, FIFO holding 2 -> next cycle instr_valid=0, imem_addr=redirect target, no stale entry ever appears.
REQ-034 RESET_PC=32'hFFFF_FFFC, zero-wait acks -> instr_pc FFFF_FFFC then 0000_0000 (wrap).
REQ-035 Assert n_rst low while imem_req=1, ack during reset -> all outputs at reset values, first post-reset request addr = RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding read to instruction memory, a 2-entry
// {instr, pc} buffer toward the decoder, and redirect handling with stale-ack drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;
  entry_t      r_fifo [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_count_after_pop;
  logic [1:0]  w_count_next;
  logic [31:0] w_target;

  assign w_pop             = instr_valid && instr_ready;
  assign w_count_after_pop = r_count - {1'b0, w_pop};
  assign w_target          = {redirect_pc[31:2], 2'b00};

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_pc_next    = w_target;
          w_state_next = S_REQ;
        end else if (w_count_after_pop < 2'd2) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          w_pc_next    = w_target;
          w_state_next = imem_ack ? S_REQ : S_DROP;
        end else if (imem_ack) begin
          w_push       = 1'b1;
          w_pc_next    = r_pc + 32'd4;
          // After this push the buffer holds after_pop+1 entries.
          w_state_next = (w_count_after_pop == 2'd0) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect) w_pc_next = w_target;
        if (imem_ack) w_state_next = S_REQ;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_count_next = redirect ? 2'd0 : (w_count_after_pop + {1'b0, w_push});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (r_state == S_REQ && redirect && !imem_ack) r_drop_addr <= r_pc;
      r_count <= w_count_next;
      if (redirect) begin
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= ~r_wr_ptr;
        if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // NOTE: buffer storage has no reset; r_count gates every read, so the
  // contents are never observed before being written.
  always_ff @(posedge clk) begin
    if (w_push && !redirect) r_fifo[r_wr_ptr] <= '{instr: imem_rdata, pc: r_pc};
  end

  // While dropping, the bus keeps the abandoned address until its ack arrives.
  assign imem_req    = (r_state != S_IDLE);
  assign imem_addr   = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign instr_valid = (r_count != 2'd0);
  assign instr       = instr_valid ? r_fifo[r_rd_ptr].instr : NOP;
  assign instr_pc    = instr_valid ? r_fifo[r_rd_ptr].pc    : 32'h0000_0000;

endmodule
